// File: rtl/pkt_slot_ring_if.sv
// Signal bundle of pkt_slot_ring: capture stream, drain stream, CPU port and head/status.
// slave is the buffer's view, master is the view of whatever drives it.
interface pkt_slot_ring_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH/8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_SLOTS  = 4
);
    localparam int CNT_W = $clog2(NUM_SLOTS) + 1;

    logic [DATA_WIDTH-1:0]            in_data;
    logic [CTRL_WIDTH-1:0]            in_ctrl;
    logic                             in_wr;
    logic                             in_rdy;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;
    logic [ADDR_WIDTH-1:0]            cpu_addr;
    logic                             cpu_we;
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] cpu_wdata;
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] cpu_rdata;
    logic                             cpu_wait;
    logic                             cpu_done;
    logic                             auto_done;
    logic                             head_valid;
    logic [ADDR_WIDTH-1:0]            head_first;
    logic [ADDR_WIDTH-1:0]            head_last;
    logic [CNT_W-1:0]                 slots_used;
    logic [15:0]                      drop_count;

    modport slave (
        input  in_data, in_ctrl, in_wr, out_rdy,
        input  cpu_addr, cpu_we, cpu_wdata, cpu_done, auto_done,
        output in_rdy, out_data, out_ctrl, out_wr,
        output cpu_rdata, cpu_wait,
        output head_valid, head_first, head_last, slots_used, drop_count
    );

    modport master (
        output in_data, in_ctrl, in_wr, out_rdy,
        output cpu_addr, cpu_we, cpu_wdata, cpu_done, auto_done,
        input  in_rdy, out_data, out_ctrl, out_wr,
        input  cpu_rdata, cpu_wait,
        input  head_valid, head_first, head_last, slots_used, drop_count
    );
endinterface

// File: rtl/pkt_slot_ring.sv
// N-slot packet buffer: captures whole packets into equal SRAM slots, hands them to the CPU
// in ring order, then drains processed slots downstream in capture order.
module pkt_slot_ring #(
    parameter int DATA_WIDTH   = 64,
    parameter int CTRL_WIDTH   = DATA_WIDTH/8,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_SLOTS    = 4,
    parameter bit DROP_ON_FULL = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    pkt_slot_ring_if.slave bus
);
    localparam int WORD_W     = CTRL_WIDTH + DATA_WIDTH;
    localparam int DEPTH      = 2**ADDR_WIDTH;
    localparam int SLOT_W     = $clog2(NUM_SLOTS);
    localparam int OFF_W      = ADDR_WIDTH - SLOT_W;
    localparam int SLOT_WORDS = DEPTH / NUM_SLOTS;
    localparam int CNT_W      = SLOT_W + 1;

    localparam logic [OFF_W:0]      CNT_ONE  = (OFF_W+1)'(1);
    localparam logic [OFF_W:0]      CNT_FULL = (OFF_W+1)'(SLOT_WORDS);
    localparam logic [SLOT_W-1:0]   PTR_ONE  = SLOT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    localparam logic [2:0] S_FREE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_HDR  = 2'd1;
    localparam logic [1:0] C_BODY = 2'd2;
    localparam logic [1:0] C_DROP = 2'd3;

    localparam logic [0:0] D_IDLE = 1'b0;
    localparam logic [0:0] D_RUN  = 1'b1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    logic [WORD_W-1:0]     mem        [DEPTH];
    logic [2:0]            slot_state [NUM_SLOTS];
    logic [ADDR_WIDTH-1:0] slot_last  [NUM_SLOTS];

    logic [SLOT_W-1:0]     wr_ptr, proc_ptr, drain_ptr;
    logic [CNT_W-1:0]      pend_cnt;
    logic [1:0]            cap_state;
    logic [OFF_W:0]        cap_cnt;
    logic                  drop_body;
    logic [15:0]           drop_cnt;
    logic [0:0]            drn_state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_W-1:0]     out_word_p1;
    logic                  vld_p1;
    logic [WORD_W-1:0]     cpu_rdata_p1;

    logic                  is_ctrl, wr_free, accept, overlong;
    logic                  cap_we, sop_store, sop_drop, ovf, eop;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic                  head_rdy, done_take, proc_adv;
    logic                  drn_start, rd_issue, drn_end;
    logic [SLOT_W-1:0]     cpu_slot;
    logic                  cpu_wr;
    logic [CNT_W-1:0]      used;

    assign is_ctrl    = |bus.in_ctrl;
    assign wr_free    = (slot_state[wr_ptr] == S_FREE);
    // Backpressure only while waiting to start a packet; a packet in flight always owns a slot.
    assign bus.in_rdy = DROP_ON_FULL ? 1'b1 : !((cap_state == C_IDLE) && !wr_free);
    assign accept     = bus.in_wr & bus.in_rdy;
    assign overlong   = (cap_cnt == CNT_FULL);
    assign cap_addr   = {wr_ptr, cap_cnt[OFF_W-1:0]};

    always_comb begin
        cap_we    = 1'b0;
        sop_store = 1'b0;
        sop_drop  = 1'b0;
        ovf       = 1'b0;
        eop       = 1'b0;
        if (accept) begin
            case (cap_state)
                C_IDLE: begin
                    if (is_ctrl && wr_free) begin
                        cap_we    = 1'b1;
                        sop_store = 1'b1;
                    end else if (is_ctrl) begin
                        sop_drop  = 1'b1;
                    end
                end
                C_HDR, C_BODY: begin
                    if (overlong) begin
                        ovf = 1'b1;
                    end else begin
                        cap_we = 1'b1;
                        eop    = (cap_state == C_BODY) && is_ctrl;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_state <= C_IDLE;
            cap_cnt   <= '0;
            drop_body <= 1'b0;
            wr_ptr    <= '0;
            drop_cnt  <= '0;
        end else begin
            if (sop_store) begin
                cap_state <= C_HDR;
                cap_cnt   <= CNT_ONE;
            end
            if (sop_drop) begin
                cap_state <= C_DROP;
                drop_body <= 1'b0;
            end
            if (cap_we && (cap_state != C_IDLE)) begin
                cap_cnt <= cap_cnt + CNT_ONE;
                if ((cap_state == C_HDR) && !is_ctrl)
                    cap_state <= C_BODY;
            end
            if (eop) begin
                cap_state <= C_IDLE;
                cap_cnt   <= '0;
                wr_ptr    <= wr_ptr + PTR_ONE;
            end
            // An overlong word that is itself the EOP ends the packet; otherwise discard to EOP.
            if (ovf) begin
                cap_cnt <= '0;
                if ((cap_state == C_BODY) && is_ctrl) begin
                    cap_state <= C_IDLE;
                end else begin
                    cap_state <= C_DROP;
                    drop_body <= (cap_state == C_BODY) || !is_ctrl;
                end
            end
            if (accept && (cap_state == C_DROP)) begin
                if (!is_ctrl)
                    drop_body <= 1'b1;
                else if (drop_body)
                    cap_state <= C_IDLE;
            end
            if (sop_drop || ovf)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // pend_cnt counts captured slots the proc pointer has not yet passed; auto-done slots are skipped.
    assign head_rdy  = (pend_cnt != '0) && (slot_state[proc_ptr] == S_READY);
    assign done_take = bus.cpu_done & head_rdy;
    assign proc_adv  = done_take | ((pend_cnt != '0) && (slot_state[proc_ptr] != S_READY));

    always_ff @(posedge clk) begin
        if (rst) begin
            proc_ptr <= '0;
            pend_cnt <= '0;
        end else begin
            if (proc_adv)
                proc_ptr <= proc_ptr + PTR_ONE;
            pend_cnt <= pend_cnt + CNT_W'(eop) - CNT_W'(proc_adv);
        end
    end

    assign drn_start = (drn_state == D_IDLE) && (slot_state[drain_ptr] == S_DONE);
    assign rd_issue  = (drn_state == D_RUN) && bus.out_rdy;
    assign drn_end   = rd_issue && (rd_addr == slot_last[drain_ptr]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                slot_state[i] <= S_FREE;
        end else begin
            if (sop_store) slot_state[wr_ptr]    <= S_FILL;
            if (ovf)       slot_state[wr_ptr]    <= S_FREE;
            if (eop)       slot_state[wr_ptr]    <= bus.auto_done ? S_DONE : S_READY;
            if (done_take) slot_state[proc_ptr]  <= S_DONE;
            if (drn_start) slot_state[drain_ptr] <= S_DRAIN;
            if (drn_end)   slot_state[drain_ptr] <= S_FREE;
        end
    end

    // p0 -> p1: drain read issued with out_rdy, word presented one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            drn_state   <= D_IDLE;
            drain_ptr   <= '0;
            vld_p1      <= 1'b0;
            out_word_p1 <= '0;
        end else begin
            vld_p1 <= rd_issue;
            if (rd_issue)
                out_word_p1 <= mem[rd_addr];
            if (drn_start) begin
                drn_state <= D_RUN;
                rd_addr   <= {drain_ptr, {OFF_W{1'b0}}};
            end
            if (rd_issue) begin
                if (drn_end) begin
                    drn_state <= D_IDLE;
                    drain_ptr <= drain_ptr + PTR_ONE;
                end else begin
                    rd_addr <= rd_addr + ADDR_ONE;
                end
            end
        end
    end

    // Capture owns the single write port; a colliding CPU write is refused via cpu_wait.
    assign cpu_slot     = bus.cpu_addr[ADDR_WIDTH-1 -: SLOT_W];
    assign bus.cpu_wait = bus.cpu_we & cap_we;
    assign cpu_wr       = bus.cpu_we & !cap_we & (slot_state[cpu_slot] == S_READY);

    always_ff @(posedge clk) begin
        if (cap_we)
            mem[cap_addr] <= {bus.in_ctrl, bus.in_data};
        else if (cpu_wr)
            mem[bus.cpu_addr] <= bus.cpu_wdata;
        if (eop)
            slot_last[wr_ptr] <= cap_addr;
    end

    // p0 -> p1: CPU read address registered into read data.
    always_ff @(posedge clk) begin
        if (rst)
            cpu_rdata_p1 <= '0;
        else
            cpu_rdata_p1 <= mem[bus.cpu_addr];
    end

    always_comb begin
        used = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            used = used + CNT_W'(slot_state[i] != S_FREE);
    end

    assign bus.out_wr                   = vld_p1;
    assign {bus.out_ctrl, bus.out_data} = out_word_p1;
    assign bus.cpu_rdata                = cpu_rdata_p1;
    assign bus.head_valid               = head_rdy;
    assign bus.head_first               = head_rdy ? {proc_ptr, {OFF_W{1'b0}}} : '0;
    assign bus.head_last                = head_rdy ? slot_last[proc_ptr] : '0;
    assign bus.slots_used               = used;
    assign bus.drop_count               = drop_cnt;
endmodule

// File: tb/tb_pkt_slot_ring.sv
// Directed bench for pkt_slot_ring: one instance drops on full, one backpressures.
// Stimulus is shared; sel routes the stream and CPU strobes to the instance under test.
module tb_pkt_slot_ring;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [63:0] s_data = '0;
    logic [7:0]  s_ctrl = '0;
    logic        s_wr = 1'b0, s_out_rdy = 1'b0, s_cpu_we = 1'b0, s_cpu_done = 1'b0, s_auto = 1'b0;
    logic [7:0]  s_cpu_addr = '0;
    logic [71:0] s_cpu_wdata = '0;
    logic        tog = 1'b0;

    int n_run = 0;
    int n_fail = 0;
    int rdy_viol = 0;
    logic rdy_last = 1'b0;
    logic [71:0] outq[$];

    pkt_slot_ring_if ifa ();
    pkt_slot_ring_if ifb ();

    pkt_slot_ring #(.DROP_ON_FULL(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pkt_slot_ring #(.DROP_ON_FULL(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    assign ifa.in_data   = s_data;          assign ifb.in_data   = s_data;
    assign ifa.in_ctrl   = s_ctrl;          assign ifb.in_ctrl   = s_ctrl;
    assign ifa.in_wr     = s_wr & !sel;     assign ifb.in_wr     = s_wr & sel;
    assign ifa.out_rdy   = s_out_rdy;       assign ifb.out_rdy   = s_out_rdy;
    assign ifa.cpu_addr  = s_cpu_addr;      assign ifb.cpu_addr  = s_cpu_addr;
    assign ifa.cpu_we    = s_cpu_we & !sel; assign ifb.cpu_we    = s_cpu_we & sel;
    assign ifa.cpu_wdata = s_cpu_wdata;     assign ifb.cpu_wdata = s_cpu_wdata;
    assign ifa.cpu_done  = s_cpu_done & !sel; assign ifb.cpu_done = s_cpu_done & sel;
    assign ifa.auto_done = s_auto;          assign ifb.auto_done = s_auto;

    logic        o_rdy, o_wr, o_wait, o_hv;
    logic [63:0] o_data;
    logic [7:0]  o_ctrl, o_hf, o_hl;
    logic [71:0] o_rdata;
    logic [2:0]  o_su;
    logic [15:0] o_dc;
    assign o_rdy   = sel ? ifb.in_rdy     : ifa.in_rdy;
    assign o_wr    = sel ? ifb.out_wr     : ifa.out_wr;
    assign o_data  = sel ? ifb.out_data   : ifa.out_data;
    assign o_ctrl  = sel ? ifb.out_ctrl   : ifa.out_ctrl;
    assign o_rdata = sel ? ifb.cpu_rdata  : ifa.cpu_rdata;
    assign o_wait  = sel ? ifb.cpu_wait   : ifa.cpu_wait;
    assign o_hv    = sel ? ifb.head_valid : ifa.head_valid;
    assign o_hf    = sel ? ifb.head_first : ifa.head_first;
    assign o_hl    = sel ? ifb.head_last  : ifa.head_last;
    assign o_su    = sel ? ifb.slots_used : ifa.slots_used;
    assign o_dc    = sel ? ifb.drop_count : ifa.drop_count;

    always #5 clk = ~clk;

    always @(posedge clk) rdy_last <= s_out_rdy;

    always @(negedge clk) begin
        if (o_wr) begin
            outq.push_back({o_ctrl, o_data});
            if (!rdy_last) rdy_viol++;
        end
    end

    always @(negedge clk) if (tog) s_out_rdy = ~s_out_rdy;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word i of an n-word test packet: header ctrl FF, body ctrl 00, EOP ctrl 04.
    function automatic logic [71:0] pw(input logic [7:0] tag, input int i, input int n);
        logic [7:0] c;
        c = (i == 0) ? 8'hFF : ((i == n - 1) ? 8'h04 : 8'h00);
        return {c, tag, 48'h0, 8'(i)};
    endfunction

    task automatic send_word(input logic [71:0] w);
        int g;
        {s_ctrl, s_data} = w;
        s_wr = 1'b1;
        g = 0;
        while (!o_rdy && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!o_rdy) check("in_rdy_timeout", 72'(o_rdy), 72'd1);
        @(negedge clk);
        s_wr = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] tag, input int n, input int first);
        for (int i = first; i < n; i++) send_word(pw(tag, i, n));
    endtask

    task automatic pulse_done();
        s_cpu_done = 1'b1;
        @(negedge clk);
        s_cpu_done = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int g;
        g = 0;
        while (outq.size() < n && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (outq.size() < n) check("out_timeout", 72'(outq.size()), 72'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        outq.delete();
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_rdata", o_rdata, 72'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_rdy", 72'(o_rdy), 72'd1);
        check("rst_out_wr", 72'(o_wr), 72'd0);
        check("rst_out_word", {o_ctrl, o_data}, 72'd0);
        check("rst_head_valid", 72'(o_hv), 72'd0);
        check("rst_head_first", 72'(o_hf), 72'd0);
        check("rst_head_last", 72'(o_hl), 72'd0);
        check("rst_slots_used", 72'(o_su), 72'd0);
        check("rst_drop_count", 72'(o_dc), 72'd0);
        check("rst_cpu_wait", 72'(o_wait), 72'd0);

        // single packet captured into slot 0
        send_pkt(8'h01, 5, 0);
        check("p1_head_valid", 72'(o_hv), 72'd1);
        check("p1_head_first", 72'(o_hf), 72'd0);
        check("p1_head_last", 72'(o_hl), 72'd4);
        check("p1_slots_used", 72'(o_su), 72'd1);

        // CPU read and edit of word 2
        s_cpu_addr = 8'd2;
        @(negedge clk);
        check("cpu_read_w2", o_rdata, pw(8'h01, 2, 5));
        s_cpu_we = 1'b1;
        s_cpu_wdata = 72'h00_DEADBEEF_00000000;
        #1 check("cpu_wait_idle", 72'(o_wait), 72'd0);
        @(negedge clk);
        s_cpu_we = 1'b0;
        @(negedge clk);
        check("cpu_readback_w2", o_rdata, 72'h00_DEADBEEF_00000000);

        // capture write collides with CPU write: CPU refused
        {s_ctrl, s_data} = pw(8'h02, 0, 5);
        s_wr = 1'b1;
        s_cpu_we = 1'b1;
        s_cpu_addr = 8'd3;
        s_cpu_wdata = 72'h11;
        #1 check("cpu_wait_hit", 72'(o_wait), 72'd1);
        @(negedge clk);
        s_wr = 1'b0;
        s_cpu_we = 1'b0;
        send_pkt(8'h02, 5, 1);
        @(negedge clk);
        check("cpu_write_refused", o_rdata, pw(8'h01, 3, 5));
        check("p2_slots_used", 72'(o_su), 72'd2);

        pulse_done();
        check("next_head_first", 72'(o_hf), 72'd64);
        check("next_head_last", 72'(o_hl), 72'd68);
        s_out_rdy = 1'b1;
        wait_out(5);
        for (int i = 0; i < 5; i++)
            check($sformatf("drain_p1_w%0d", i), outq[i],
                  (i == 2) ? 72'h00_DEADBEEF_00000000 : pw(8'h01, i, 5));
        check("after_drain1_used", 72'(o_su), 72'd1);
        pulse_done();
        wait_out(10);
        for (int i = 0; i < 5; i++)
            check($sformatf("drain_p2_w%0d", i), outq[5 + i], pw(8'h02, i, 5));
        check("after_drain2_used", 72'(o_su), 72'd0);

        // full ring with drop: slots 2,3,0,1 fill, fifth packet dropped
        s_out_rdy = 1'b0;
        for (int p = 0; p < 5; p++) send_pkt(8'h40 + 8'(p), 3, 0);
        check("full_slots_used", 72'(o_su), 72'd4);
        check("full_drop_count", 72'(o_dc), 72'd1);
        check("full_in_rdy", 72'(o_rdy), 72'd1);
        check("full_head_first", 72'(o_hf), 72'd128);
        check("full_head_last", 72'(o_hl), 72'd130);

        // full ring with backpressure
        sel = 1'b1;
        do_reset();
        for (int p = 0; p < 4; p++) send_pkt(8'h50 + 8'(p), 3, 0);
        check("bp_in_rdy_low", 72'(o_rdy), 72'd0);
        check("bp_slots_used", 72'(o_su), 72'd4);
        fork
            send_pkt(8'h54, 3, 0);
            begin
                pulse_done();
                s_out_rdy = 1'b1;
            end
        join
        wait_out(3);
        for (int i = 0; i < 3; i++)
            check($sformatf("bp_drain0_w%0d", i), outq[i], pw(8'h50, i, 3));
        check("bp_refill_used", 72'(o_su), 72'd4);
        check("bp_head_first", 72'(o_hf), 72'd64);
        repeat (4) pulse_done();
        wait_out(15);
        for (int i = 0; i < 3; i++)
            check($sformatf("bp_fifth_w%0d", i), outq[12 + i], pw(8'h54, i, 3));
        check("bp_drop_count", 72'(o_dc), 72'd0);
        check("bp_empty_used", 72'(o_su), 72'd0);

        // auto_done store-and-forward with out_rdy toggling
        sel = 1'b0;
        s_out_rdy = 1'b0;
        s_auto = 1'b1;
        do_reset();
        rdy_viol = 0;
        tog = 1'b1;
        for (int p = 0; p < 3; p++) send_pkt(8'h60 + 8'(p), 4, 0);
        wait_out(12);
        tog = 1'b0;
        s_out_rdy = 1'b0;
        for (int i = 0; i < 12; i++)
            check($sformatf("auto_w%0d", i), outq[i], pw(8'h60 + 8'(i / 4), i % 4, 4));
        check("auto_head_valid", 72'(o_hv), 72'd0);
        check("auto_rdy_order", 72'(rdy_viol), 72'd0);

        // overlong packet, then a normal one, then reset mid-capture
        s_auto = 1'b0;
        do_reset();
        send_pkt(8'h70, 66, 0);
        check("ovl_drop_count", 72'(o_dc), 72'd1);
        check("ovl_slots_used", 72'(o_su), 72'd0);
        send_pkt(8'h71, 4, 0);
        check("ovl_next_valid", 72'(o_hv), 72'd1);
        check("ovl_next_first", 72'(o_hf), 72'd0);
        check("ovl_next_last", 72'(o_hl), 72'd3);
        send_word(pw(8'h72, 0, 4));
        send_word(pw(8'h72, 1, 4));
        check("mid_slots_used", 72'(o_su), 72'd2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_slots_used", 72'(o_su), 72'd0);
        check("midrst_out_wr", 72'(o_wr), 72'd0);
        check("midrst_head_valid", 72'(o_hv), 72'd0);
        check("midrst_drop_count", 72'(o_dc), 72'd0);
        rst = 1'b0;
        s_out_rdy = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_drain", 72'(outq.size()), 72'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
